// File: rtl/sprite_motion_ctrl.sv
// Per-frame sprite motion sequencer: steps the sprite on each frame rise, reflects it off
// the screen edges, rotates the one-hot overlay colour on bounces and handles a debounced pause.
module sprite_motion_ctrl #(
  parameter int unsigned SCREEN_W      = 800,
  parameter int unsigned SCREEN_H      = 480,
  parameter int unsigned SPRITE_W      = 256,
  parameter int unsigned SPRITE_H      = 128,
  parameter int unsigned INIT_X        = 300,
  parameter int unsigned INIT_Y        = 200,
  parameter int unsigned DEBOUNCE_BITS = 16
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       frame,
  input  logic       btn_pause,
  input  logic [1:0] speed,
  output logic [9:0] x_pos,
  output logic [9:0] y_pos,
  output logic [2:0] color,
  output logic       bounce,
  output logic       corner,
  output logic       paused
);

  localparam logic [10:0] MaxX  = 11'(SCREEN_W - SPRITE_W);
  localparam logic [10:0] MaxY  = 11'(SCREEN_H - SPRITE_H);
  localparam logic [9:0]  InitX = 10'(INIT_X);
  localparam logic [9:0]  InitY = 10'(INIT_Y);

  typedef enum logic [1:0] {StIdle, StStepX, StStepY, StCommit} state_e;

  state_e state_q, state_d;
  logic   frame_q, rise;
  logic [2:0] step_q;
  logic [9:0] x_q, y_q, nx_q, ny_q;
  logic       xdir_q, ydir_q, nxdir_q, nydir_q, hx_q, hy_q;
  logic [2:0] color_q;
  logic       bounce_q, corner_q;

  logic [1:0]               sync_q;
  logic                     stable_q, stable_d;
  logic [DEBOUNCE_BITS-1:0] cnt_q, cnt_d;
  logic                     paused_q, press;

  // Returns {hit, next_dir, next_pos}; dir = 1 means increasing. Overshoot clamps to the edge.
  function automatic logic [11:0] axis_next(input logic [9:0] pos, input logic dir,
                                            input logic [2:0] step, input logic [10:0] lim);
    logic [10:0] pos_e, step_e, sum, diff;
    pos_e  = {1'b0, pos};
    step_e = {8'b0, step};
    sum    = pos_e + step_e;
    diff   = pos_e - step_e;
    if (dir) begin
      if (sum >= lim) axis_next = {1'b1, 1'b0, lim[9:0]};
      else            axis_next = {1'b0, 1'b1, sum[9:0]};
    end else begin
      if (pos_e <= step_e) axis_next = {1'b1, 1'b1, 10'd0};
      else                 axis_next = {1'b0, 1'b0, diff[9:0]};
    end
  endfunction

  assign rise = frame & ~frame_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (rise && !paused_q) state_d = StStepX;
      StStepX:  state_d = StStepY;
      StStepY:  state_d = StCommit;
      StCommit: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Debounce: stable follows the synced button only after it has differed for a full count.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (sync_q[1] == stable_q) begin
      cnt_d = '0;
    end else if (&cnt_q) begin
      stable_d = sync_q[1];
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + DEBOUNCE_BITS'(1);
    end
  end

  assign press = stable_q & ~stable_d;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= StIdle;
      frame_q  <= 1'b1;
      step_q   <= 3'd1;
      x_q      <= InitX;
      y_q      <= InitY;
      xdir_q   <= 1'b1;
      ydir_q   <= 1'b1;
      nx_q     <= InitX;
      ny_q     <= InitY;
      nxdir_q  <= 1'b1;
      nydir_q  <= 1'b1;
      hx_q     <= 1'b0;
      hy_q     <= 1'b0;
      color_q  <= 3'b001;
      bounce_q <= 1'b0;
      corner_q <= 1'b0;
      sync_q   <= 2'b11;
      stable_q <= 1'b1;
      cnt_q    <= '0;
      paused_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      frame_q  <= frame;
      sync_q   <= {sync_q[0], btn_pause};
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      paused_q <= paused_q ^ press;
      bounce_q <= 1'b0;
      corner_q <= 1'b0;
      if (state_q == StIdle && rise && !paused_q) step_q <= {1'b0, speed} + 3'd1;
      if (state_q == StStepX) {hx_q, nxdir_q, nx_q} <= axis_next(x_q, xdir_q, step_q, MaxX);
      if (state_q == StStepY) {hy_q, nydir_q, ny_q} <= axis_next(y_q, ydir_q, step_q, MaxY);
      if (state_q == StCommit) begin
        x_q      <= nx_q;
        y_q      <= ny_q;
        xdir_q   <= nxdir_q;
        ydir_q   <= nydir_q;
        if (hx_q | hy_q) color_q <= {color_q[1:0], color_q[2]};
        bounce_q <= hx_q | hy_q;
        corner_q <= hx_q & hy_q;
      end
    end
  end

  assign x_pos  = x_q;
  assign y_pos  = y_q;
  assign color  = color_q;
  assign bounce = bounce_q;
  assign corner = corner_q;
  assign paused = paused_q;

endmodule
